ram8_fifo_ctrl: RTL and testbench

- FIFO controller that sits directly upstream of the 8-word RAM8 and drives its in/load/address ports.
- Consumes RAM8's out through a registered head stage.
- Turns the single-port RAM8 into an 8+1 deep, 16-bit, valid/ready FIFO for producer/consumer stages in the CPU datapath.
- RAM8 is instantiated beside this block at the next level up, not inside it.

---
 rtl/ram8_fifo_pkg.sv | 15 +
 rtl/ram8_fifo_ptr.sv | 39 +++
 rtl/ram8_fifo_ctrl.sv | 134 +++++++++++++
 tb/tb_ram8_fifo_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram8_fifo_pkg.sv
// Shared constants for the RAM8-backed FIFO controller.
package ram8_fifo_pkg;

  localparam int WORD_W     = 16;
  localparam int RAM_ADDR_W = 3;
  localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;
  localparam int LEVEL_W    = 4;

  // Occupancy encoding of the RAM portion: DEPTH words fits in LEVEL_W bits,
  // and DEPTH + head register (9) still fits.
  function automatic logic [LEVEL_W-1:0] depth_count();
    return LEVEL_W'(RAM_DEPTH);
  endfunction

endpackage

// File: rtl/ram8_fifo_ptr.sv
// Wrapping RAM8 address pointer: increments modulo 2**ADDR_W, synchronous clear
// has priority over increment, asynchronous active-low reset to zero.
module ram8_fifo_ptr
  import ram8_fifo_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  // Next pointer: clear wins, otherwise natural binary wrap 7 -> 0.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ram8_fifo_ctrl.sv
// FIFO controller driving an external single-port RAM8 (8 x 16) plus a
// registered head stage, giving an 8+1 deep valid/ready FIFO.
//
// Handshake: a word moves on a port in every cycle where its valid and ready
// are both high at the rising edge; valid never waits for ready, and pop_data
// holds steady while pop_valid is high and pop_ready is low.
//
// The RAM has one port, so a head refill (read) blocks a push that cycle.
// Optional build macro RAM8_FIFO_BYPASS_EN: a push into a completely empty
// FIFO with a free head register goes straight to pop_data (1-cycle latency).
module ram8_fifo_ctrl
  import ram8_fifo_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [WIDTH-1:0]   push_data,
  output logic               pop_valid,
  input  logic               pop_ready,
  output logic [WIDTH-1:0]   pop_data,
  output logic [WIDTH-1:0]   ram_in,
  output logic               ram_load,
  output logic [ADDR_W-1:0]  ram_address,
  input  logic [WIDTH-1:0]   ram_out,
  output logic [LEVEL_W-1:0] level,
  output logic               full
);

  localparam logic [LEVEL_W-1:0] DEPTH_CNT = depth_count();

  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [LEVEL_W-1:0] count_q;
  logic [LEVEL_W-1:0] count_d;
  logic               out_valid_q;
  logic               out_valid_d;
  logic [WIDTH-1:0]   pop_data_q;
  logic [WIDTH-1:0]   pop_data_d;

  logic pop_fire;
  logic out_free;
  logic ram_empty;
  logic do_read;
  logic do_write;
  logic bypass;

  // Per-cycle operation decode: read refill has priority over a push.
  always_comb begin
    pop_fire  = out_valid_q & pop_ready;
    out_free  = !out_valid_q | pop_fire;
    ram_empty = (count_q == '0);
    do_read   = out_free & !ram_empty & !flush;
`ifdef RAM8_FIFO_BYPASS_EN
    bypass    = rst_n & ram_empty & out_free & push_valid & !flush;
`else
    bypass    = 1'b0;
`endif
    push_ready = (rst_n & !flush & (count_q != DEPTH_CNT) & !do_read) | bypass;
    do_write   = push_valid & push_ready & !bypass;
  end

  // RAM8 drive: the single address serves the read when one is pending.
  always_comb begin
    ram_address = do_read ? rd_ptr : wr_ptr;
    ram_load    = do_write;
    ram_in      = push_data;
  end

  // Head register and occupancy next-state; flush empties everything.
  always_comb begin
    count_d     = count_q;
    out_valid_d = out_valid_q;
    pop_data_d  = pop_data_q;
    if (flush) begin
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (do_read) begin
        pop_data_d  = ram_out;
        out_valid_d = 1'b1;
      end else if (bypass) begin
        pop_data_d  = push_data;
        out_valid_d = 1'b1;
      end else if (pop_fire) begin
        out_valid_d = 1'b0;
      end
      if (do_read) begin
        count_d = count_q - 1'b1;
      end else if (do_write) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  ram8_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (do_write),
    .ptr_o (wr_ptr)
  );

  ram8_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (do_read),
    .ptr_o (rd_ptr)
  );

  assign pop_valid = out_valid_q;
  assign pop_data  = pop_data_q;
  assign level     = count_q + LEVEL_W'(out_valid_q);
  assign full      = (count_q == DEPTH_CNT);

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// Bench for ram8_fifo_ctrl with a behavioural RAM8 beside it. Inputs change
// 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ram8_fifo_ctrl;

  localparam int W  = 16;
  localparam int AW = 3;
`ifdef RAM8_FIFO_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic          pop_ready = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          push_ready, pop_valid, ram_load, full;
  logic [W-1:0]  pop_data, ram_in, ram_out;
  logic [AW-1:0] ram_address;
  logic [3:0]    level;

  always #5 clk = ~clk;

  ram8_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
    .ram_out(ram_out), .level(level), .full(full)
  );

  // Behavioural RAM8: combinational read, write on the rising edge.
  logic [W-1:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = '0;
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  // ---------------- scoreboard state ----------------
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  int           cyc = 0;
  int           wr_cyc_log[$];
  int           wr_addr_log[$];
  int           exp_wr_addr = 0;
  int           pop_count = 0;
  logic [W-1:0] last_pop = '0;
  bit           hold_valid = 0;
  logic [W-1:0] hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Stimulus side: every accepted push becomes an expected pop, in order;
  // RAM writes are expected at consecutive addresses modulo 8 since clear.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_wr_addr = 0;
    end else if (flush) begin
      check("flush_no_write", ram_load, 0);
      exp_wr_addr = 0;
    end else begin
      if (push_valid && push_ready) exp_q.push_back(push_data);
      if (ram_load) begin
        check("wr_addr", ram_address, exp_wr_addr);
        wr_cyc_log.push_back(cyc);
        wr_addr_log.push_back(int'(ram_address));
        exp_wr_addr = (exp_wr_addr + 1) % 8;
      end
    end
  end

  // Monitor: level/full against the model, head stability, popped data.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_valid = 0;
    end else begin
      check("level", level, exp_q.size());
      check("full", full, exp_q.size() == 9);
      if (exp_q.size() == 9) check("full_push_ready", push_ready, 0);
      if (hold_valid) begin
        check("hold_valid", pop_valid, 1);
        check("hold_data", pop_data, hold_data);
      end
      if (pop_valid && pop_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_on_empty: got data 0x%0h expected no word at t=%0t", pop_data, $time);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (pop_data !== e) begin
            failures++;
            $display("FAIL pop_data: got 0x%0h expected 0x%0h at t=%0t", pop_data, e, $time);
          end
        end
        pop_count++;
        last_pop = pop_data;
      end
      hold_valid = pop_valid && !pop_ready && !flush;
      hold_data  = pop_data;
      if (flush) exp_q.delete();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [W-1:0] d, input int max_wait, output bit ok);
    push_valid = 1'b1;
    push_data  = d;
    ok = 0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (push_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    push_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    bit done;
    done = 0;
    pop_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (level == 0) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout: level 0x%0h expected 0x0 within %0d cycles", level, max_cycles);
    end
    @(posedge clk); #1;
    pop_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    int p0, lat;

    // Reset: push attempt during reset must see no ready and no RAM load.
    push_valid = 1'b1;
    push_data  = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_push_ready", push_ready, 0);
    check("rst_ram_load", ram_load, 0);
    push_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pop_valid", pop_valid, 0);
    check("rst_pop_data", pop_data, 0);
    check("rst_level", level, 0);
    check("rst_push_ready_after", push_ready, 1);
    @(posedge clk); #1;

    // Test 1: three pushes, consumer stalled.
    wr_cyc_log.delete();
    wr_addr_log.delete();
    push_word(16'h1111, 4, ok); check("t1_acc0", ok, 1);
    push_word(16'h2222, 4, ok); check("t1_acc1", ok, 1);
    push_word(16'h3333, 4, ok); check("t1_acc2", ok, 1);
    @(negedge clk);
    check("t1_pop_data", pop_data, 16'h1111);
    check("t1_level", level, 3);
    check("t1_nwrites", wr_addr_log.size(), 3 - BYP);
    for (int i = 0; i < wr_addr_log.size(); i++) check("t1_addr", wr_addr_log[i], i);
    if (wr_cyc_log.size() >= 2) check("t1_gap", wr_cyc_log[1] - wr_cyc_log[0], BYP ? 1 : 2);
    @(posedge clk); #1;
    do_flush();

    // Test 2: overfill with 10 words, then drain in order.
    for (int i = 1; i <= 10; i++) begin
      push_word(W'(i), 4, ok);
      check("t2_accept", ok, i <= 9);
    end
    @(negedge clk);
    check("t2_push_ready", push_ready, 0);
    check("t2_full", full, 1);
    check("t2_level", level, 9);
    @(posedge clk); #1;
    p0 = pop_count;
    drain(40);
    check("t2_pops", pop_count - p0, 9);
    check("t2_last", last_pop, 16'h0009);
    do_flush();

    // Test 3: 20-word stream with a continuously ready consumer.
    pop_ready = 1'b1;
    p0 = pop_count;
    for (int i = 0; i < 20; i++) begin
      push_word(W'(16'h5000 + i), 8, ok);
      check("t3_accept", ok, 1);
    end
    drain(40);
    check("t3_pops", pop_count - p0, 20);
    check("t3_last", last_pop, 16'h5013);
    do_flush();

    // Test 4: read refill beats a simultaneous push.
    for (int i = 0; i < 4; i++) begin
      push_word(W'(16'h4000 + i), 4, ok);
      check("t4_fill", ok, 1);
    end
    @(negedge clk);
    check("t4_level", level, 4);
    @(posedge clk); #1;
    pop_ready  = 1'b1;
    push_valid = 1'b1;
    push_data  = 16'h4444;
    @(negedge clk);
    check("t4_push_blocked", push_ready, 0);
    check("t4_no_load", ram_load, 0);
    check("t4_rd_addr", ram_address, BYP ? 0 : 1);
    @(posedge clk); #1;
    pop_ready = 1'b0;
    @(negedge clk);
    check("t4_push_next", push_ready, 1);
    @(posedge clk); #1;
    push_valid = 1'b0;
    drain(40);
    do_flush();

    // Test 5: flush a partly full FIFO, then measure first-word latency.
    for (int i = 0; i < 5; i++) push_word(W'(16'h7700 + i), 4, ok);
    do_flush();
    @(negedge clk);
    check("t5_level_flushed", level, 0);
    check("t5_valid_flushed", pop_valid, 0);
    @(posedge clk); #1;
    push_word(16'hABCD, 4, ok);
    check("t5_accept", ok, 1);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lat++;
      if (pop_valid) break;
    end
    check("t5_latency", lat, BYP ? 1 : 2);
    check("t5_data", pop_data, 16'hABCD);
    @(posedge clk); #1;
    drain(10);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      push_valid = 1'($urandom_range(0, 1));
      push_data  = W'($urandom);
      pop_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    push_valid = 1'b0;
    flush      = 1'b0;
    drain(40);

    // Test 6: asynchronous reset between edges during streaming.
    pop_ready  = 1'b1;
    push_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_data = W'(16'h6600 + i);
      @(posedge clk); #1;
    end
    pop_ready = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t6_pop_valid", pop_valid, 0);
    check("t6_push_ready", push_ready, 0);
    check("t6_ram_load", ram_load, 0);
    check("t6_level", level, 0);
    push_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_empty_level", level, 0);
    check("t6_empty_valid", pop_valid, 0);
    check("t6_ready_back", push_ready, 1);
    check("t6_full", full, 0);
    @(posedge clk); #1;
    push_word(16'h0BAD, 4, ok);
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
